// File: rtl/fp_to_int_seq_pkg.sv
// Shared types and elaboration helpers for the float-to-integer decoder.
// Holds the state encoding, flag bit positions and width helpers.
package fp_to_int_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALIGN  = 2'd1,
    FINISH = 2'd2,
    DONE   = 2'd3
  } fp2i_state_t;

  localparam int FLG_INVALID  = 2;
  localparam int FLG_OVERFLOW = 1;
  localparam int FLG_INEXACT  = 0;

  function automatic int EXP_OFFSET(input int nx);
    return (1 << (nx - 1)) - 1;
  endfunction

  function automatic int MAX(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int ABS(input int a);
    return (a < 0) ? -a : a;
  endfunction

  // Width that holds (e - NM) as a signed value over the full exponent range.
  function automatic int SC_WIDTH(input int nx, input int nm);
    return MAX(nx + 1, $clog2(nm + 1) + 1) + 1;
  endfunction

endpackage

// File: rtl/fp_to_int_seq_classify.sv
// Combinational classifier: special-value detection, unbiased exponent,
// and the alignment shift count/direction for the normal path.
module fp_to_int_seq_classify
  import fp_to_int_seq_pkg::*;
#(
  parameter int NX  = 8,
  parameter int NM  = 23,
  parameter int SCW = SC_WIDTH(NX, NM)
) (
  input  logic [NX+NM:0]    fp_in,
  output logic              is_neg,
  output logic              mant_nz,
  output logic              is_nan,
  output logic              is_inf,
  output logic              is_zero,
  output logic signed [NX:0] e,
  output logic [SCW-1:0]    sc,
  output logic              dir_left
);

  typedef struct packed {
    logic          sign;
    logic [NX-1:0] exp;
    logic [NM-1:0] mant;
  } ieee754_t;

  localparam int            BIAS     = EXP_OFFSET(NX);
  localparam logic [NX:0]   BIAS_V   = BIAS[NX:0];
  localparam logic [NX-1:0] EXP_ONES = {NX{1'b1}};
  localparam logic [SCW-1:0] NM_V    = NM[SCW-1:0];
  localparam logic [SCW-1:0] SC_ONE  = {{(SCW-1){1'b0}}, 1'b1};

  ieee754_t       f;
  logic [SCW-1:0] d;

  assign f = fp_in;

  // Decode fields; d = e - NM as a two's-complement pattern in SCW bits.
  always_comb begin
    is_neg   = f.sign;
    mant_nz  = |f.mant;
    is_nan   = (f.exp == EXP_ONES) && mant_nz;
    is_inf   = (f.exp == EXP_ONES) && !mant_nz;
    is_zero  = (f.exp == {NX{1'b0}});
    e        = $signed({1'b0, f.exp} - BIAS_V);
    d        = {{(SCW-NX-1){e[NX]}}, e} - NM_V;
    if (d[SCW-1]) begin
      sc = ~d + SC_ONE;
    end else begin
      sc = d;
    end
    dir_left = !d[SCW-1] && (d != {SCW{1'b0}});
  end

endmodule

// File: rtl/fp_to_int_seq.sv
// Sequential IEEE754 to signed-integer converter, round toward zero.
// Mantissa alignment runs one bit per cycle; results leave on valid/ready.
module fp_to_int_seq
  import fp_to_int_seq_pkg::*;
#(
  parameter int NX   = 8,
  parameter int NM   = 23,
  parameter int NOUT = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [NX+NM:0]   IN_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [NOUT-1:0]  OUT_DATA,
  output logic [2:0]       OUT_FLAGS
);

  localparam int AW  = MAX(NOUT, NM + 1) + 1;
  localparam int SCW = SC_WIDTH(NX, NM);

  localparam logic [AW-1:0]   ACC_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]   MIN_MAG = ACC_ONE << (NOUT - 1);
  localparam logic [AW-1:0]   POS_MAX = MIN_MAG - ACC_ONE;
  localparam logic [SCW-1:0]  SC_ONE  = {{(SCW-1){1'b0}}, 1'b1};
  localparam logic [NOUT-1:0] OUT_ONE = {{(NOUT-1){1'b0}}, 1'b1};

  logic              cls_neg, cls_mant_nz, cls_nan, cls_inf, cls_zero, cls_left;
  logic signed [NX:0] cls_e;
  logic [SCW-1:0]    cls_sc;
  int                e_i;
  logic              accept;

  fp2i_state_t     state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [SCW-1:0]  sc_q, sc_d;
  logic            dir_q, dir_d;
  logic            neg_q, neg_d;
  logic            sticky_q, sticky_d;
  logic [2:0]      flg_q, flg_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [NOUT-1:0] out_data_q, out_data_d;
  logic [2:0]      out_flags_q, out_flags_d;
  logic [NOUT-1:0] mag;

  fp_to_int_seq_classify #(
    .NX  (NX),
    .NM  (NM),
    .SCW (SCW)
  ) u_classify (
    .fp_in    (IN_DATA),
    .is_neg   (cls_neg),
    .mant_nz  (cls_mant_nz),
    .is_nan   (cls_nan),
    .is_inf   (cls_inf),
    .is_zero  (cls_zero),
    .e        (cls_e),
    .sc       (cls_sc),
    .dir_left (cls_left)
  );

  assign e_i       = int'(cls_e);
  assign accept    = IN_VALID && in_ready_q;
  assign mag       = acc_q[NOUT-1:0];
  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_FLAGS = out_flags_q;

  // Next-state logic; specials preload acc/neg so FINISH applies one formula.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    sc_d        = sc_q;
    dir_d       = dir_q;
    neg_d       = neg_q;
    sticky_d    = sticky_q;
    flg_d       = flg_q;
    out_data_d  = out_data_q;
    out_flags_d = out_flags_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          flg_d    = 3'b000;
          sticky_d = 1'b0;
          neg_d    = cls_neg;
          sc_d     = {SCW{1'b0}};
          dir_d    = 1'b0;
          acc_d    = {AW{1'b0}};
          state_d  = FINISH;
          if (cls_nan) begin
            acc_d              = POS_MAX;
            neg_d              = 1'b0;
            flg_d[FLG_INVALID] = 1'b1;
          end else if (cls_inf) begin
            acc_d               = cls_neg ? MIN_MAG : POS_MAX;
            flg_d[FLG_OVERFLOW] = 1'b1;
          end else if (cls_zero) begin
            flg_d[FLG_INEXACT] = cls_mant_nz;
          end else if (e_i < 0) begin
            flg_d[FLG_INEXACT] = 1'b1;
          end else if (e_i >= NOUT - 1) begin
            if (cls_neg && (e_i == NOUT - 1) && !cls_mant_nz) begin
              acc_d = MIN_MAG;
            end else begin
              acc_d               = cls_neg ? MIN_MAG : POS_MAX;
              flg_d[FLG_OVERFLOW] = 1'b1;
            end
          end else begin
            acc_d = {{(AW-NM-1){1'b0}}, 1'b1, IN_DATA[NM-1:0]};
            sc_d  = cls_sc;
            dir_d = cls_left;
            if (cls_sc != {SCW{1'b0}}) begin
              state_d = ALIGN;
            end else begin
              state_d = FINISH;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      ALIGN: begin
        if (dir_q) begin
          acc_d = {acc_q[AW-2:0], 1'b0};
        end else begin
          acc_d    = {1'b0, acc_q[AW-1:1]};
          sticky_d = sticky_q | acc_q[0];
        end
        sc_d = sc_q - SC_ONE;
        if (sc_q == SC_ONE) begin
          state_d = FINISH;
        end else begin
          state_d = ALIGN;
        end
      end
      FINISH: begin
        out_data_d  = neg_q ? (~mag + OUT_ONE) : mag;
        out_flags_d = flg_q | {2'b00, sticky_q};
        state_d     = DONE;
      end
      DONE: begin
        if (out_valid_q && OUT_READY) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_q == DONE) && !(out_valid_q && OUT_READY);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      acc_q       <= {AW{1'b0}};
      sc_q        <= {SCW{1'b0}};
      dir_q       <= 1'b0;
      neg_q       <= 1'b0;
      sticky_q    <= 1'b0;
      flg_q       <= 3'b000;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= {NOUT{1'b0}};
      out_flags_q <= 3'b000;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sc_q        <= sc_d;
      dir_q       <= dir_d;
      neg_q       <= neg_d;
      sticky_q    <= sticky_d;
      flg_q       <= flg_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_flags_q <= out_flags_d;
    end
  end

endmodule

// File: doc/fp_to_int_seq.md
Name: fp_to_int_seq

Overview:
- Sequential IEEE754-to-signed-integer decoder; the receiving end of the team's int-to-float encoder path.
- Accepts one packed float per handshake on a valid/ready input and aligns the mantissa iteratively, one bit per cycle.
- Returns a two's-complement integer, rounded toward zero, with exception flags on a valid/ready output.
- Sits between the FP datapath and integer consumers.

Parameters:
- NX, 8, exponent width
- NM, 23, stored mantissa width
- NOUT, 32, output integer width (NOUT >= 2)

Ports:
- CLK  in  1  single clock, rising edge
- RST  in  1  synchronous active-high reset
- IN_VALID  in  1  input word valid
- IN_READY  out  1  block can accept input
- IN_DATA  in  1+NX+NM  packed IEEE754 value {sign, exp, mant}
- OUT_VALID  out  1  result valid
- OUT_READY  in  1  consumer accepts result
- OUT_DATA  out  NOUT  signed integer result
- OUT_FLAGS  out  3  {invalid, overflow, inexact}

Behaviour:
- Interface: one clock (CLK); reset (RST) is synchronous and active-high.
- Reset values:
  - state IDLE; IN_READY=1, OUT_VALID=0, OUT_DATA=0, OUT_FLAGS=0.
  - RST mid-operation aborts the in-flight conversion with no output.
- Handshake:
  - Input is accepted on the edge where IN_VALID & IN_READY.
  - IN_READY=1 only in IDLE, so one conversion is in flight at a time.
  - OUT_VALID, OUT_DATA and OUT_FLAGS hold stable until the edge where OUT_VALID & OUT_READY, then the state returns to IDLE.
- Decode on accept, with bias = EXP_OFFSET(NX) and e = exp - bias:
  - exp all ones, mant != 0 (NaN): result 2^(NOUT-1)-1, invalid=1, skip ALIGN.
  - exp all ones, mant == 0 (Inf): saturate (+max or -2^(NOUT-1)), overflow=1, skip ALIGN.
  - exp == 0 (zero or denormal): result 0; inexact = (mant != 0); skip ALIGN.
  - e < 0: result 0, inexact=1, skip ALIGN.
  - e >= NOUT-1: saturate, overflow=1, skip ALIGN. Exception: sign=1, e==NOUT-1 and mant==0 gives exactly -2^(NOUT-1) with no flags.
  - Otherwise: acc = {1, mant} zero-extended to AW = MAX(NOUT, NM+1)+1 bits; sc = ABS(e - NM); direction is left if e > NM, else right.
- FSM states and transitions:
  - IDLE: on accept -> ALIGN if sc > 0, else FINISH.
  - ALIGN: shift acc one bit per cycle in the stored direction and decrement sc. On right shifts, the dropped LSB ORs into sticky. Go to FINISH when sc reaches 0.
  - FINISH: OUT_DATA = sign ? -acc[NOUT-1:0] : acc[NOUT-1:0]; inexact = sticky; -> DONE.
  - DONE: OUT_VALID=1; on OUT_READY -> IDLE.
- Latency: OUT_VALID is first high sc+2 cycles after the accepting edge (sc=0 for special cases).
- Sticky and flags clear on every accept.
- Arithmetic: all unsigned until FINISH. Negation is two's complement in NOUT bits. Flags are mutually exclusive except for inexact with none.

Decomposition:
- Shared package fp:
  - reuse EXP_OFFSET, MAX, ABS and the IEEE754(NX, NM) packed struct for IN_DATA decode.
  - add localparam state enum fp2i_state_t {IDLE, ALIGN, FINISH, DONE}.
  - add flag bit index constants FLG_INVALID=2, FLG_OVERFLOW=1, FLG_INEXACT=0.
- Sub-module fp_classify: purely combinational. Inputs: packed float. Outputs: is_nan, is_inf, is_zero, e (signed NX+1 bits), sc, dir. The top instantiates it and owns the FSM and shifter.

Test Plan:
- 1.0 (0x3F800000), OUT_READY=1 -> OUT_DATA=0x00000001, flags=000, OUT_VALID 25 cycles after accept.
- -2.5 (0xC0200000) -> OUT_DATA=0xFFFFFFFE, flags=001, latency 24.
- 2^31 (0x4F000000) -> 0x7FFFFFFF, flags=010, latency 2. -2^31 (0xCF000000) -> 0x80000000, flags=000, latency 2.
- NaN 0x7FC00000 -> 0x7FFFFFFF, flags=100. -Inf 0xFF800000 -> 0x80000000, flags=010. 0.5 (0x3F000000) -> 0, flags=001. +0 -> 0, flags=000.
- Backpressure: 100.0 (0x42C80000) with OUT_READY low for 5 cycles -> OUT_DATA=0x00000064 held stable, IN_READY=0 throughout; a second IN_VALID is not accepted until the cycle after OUT_READY.
- Reset mid-ALIGN: assert RST during conversion of 1.0 -> next cycle IN_READY=1, OUT_VALID=0. A following 3.0 (0x40400000) yields 0x00000003 with no residue from the aborted conversion.
